// File: rtl/rx_serial_pkg.sv
// Shared constants for the 8N1 UART receiver: FSM state encodings, data
// width and the bit-period counter width helper.
// Latency: n/a (package). Backpressure: n/a.
package rx_serial_pkg;

    localparam int DATA_BITS = 8;

    // FSM state encodings, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Width of a counter that must reach rconst-1.
    function automatic int cnt_width(input int rconst);
        return (rconst > 1) ? $clog2(rconst) : 1;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, resets to idle (1).
// Latency: 2 cycles pin-to-o_q. Backpressure: none (free-running).
//
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset (both stages load 1)
//   i_d        asynchronous input
//   o_q        synchronized output (second stage)
//   o_q_early  first-stage output, one cycle ahead of o_q; only meant as a
//              look-ahead tap that is outvoted by its fully synchronized
//              neighbours when it disagrees
module rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_q_early
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q       = r_sync;
    assign o_q_early = r_meta;

endmodule

// File: rtl/rx_serial.sv
// UART receiver, 8N1, LSB first; one-cycle ready strobe per byte, ferr on bad stop bit.
// Latency: ready/ferr assert t0+RCONST/2+9*RCONST+1 (t0 = first cycle synchronized line is low).
// Backpressure: none; the consumer must take rbyte on the ready strobe.
//
// Ports:
//   clk100  system clock        reset  synchronous active-high reset
//   rx      async serial input (idle 1)
//   rbyte   last good byte (held)  ready  byte strobe
//   ferr    framing error strobe   busy   frame or break in progress
// Build option: define RX_SERIAL_MAJORITY_EN for 2-of-3 voting around each
// bit centre; otherwise a single sample at the centre cycle is used.
module rx_serial
    import rx_serial_pkg::*;
#(
    parameter int RCONST = 108  // clock cycles per bit, must be >= 8
) (
    input  logic                 clk100,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rbyte,
    output logic                 ready,
    output logic                 ferr,
    output logic                 busy
);

    localparam int             CW        = cnt_width(RCONST);
    localparam int             HALF      = RCONST / 2;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(RCONST - 1);
    // Loaded on the t0 edge so the counter hits CNT_LAST at t0+HALF.
    localparam logic [CW-1:0]  CNT_START = CW'(RCONST - HALF);

    logic                 w_rxs;
    logic                 w_rxs_early;
    logic                 w_sample;
    logic                 w_tick;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bidx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rbyte;
    logic                 r_ready;
    logic                 r_ferr;

    rx_sync u_sync (
        .i_clk     (clk100),
        .i_reset   (reset),
        .i_d       (rx),
        .o_q       (w_rxs),
        .o_q_early (w_rxs_early)
    );

`ifdef RX_SERIAL_MAJORITY_EN
    // Vote over rxs at centre-1, centre and centre+1. The centre+1 value is
    // taken from the synchronizer's first stage (it becomes rxs next cycle),
    // so the registered decision lands at centre+1 and strobe timing matches
    // the single-sample build.
    logic r_rxs_d;

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_rxs_d <= 1'b1;
        end else begin
            r_rxs_d <= w_rxs;
        end
    end

    assign w_sample = (r_rxs_d & w_rxs) | (r_rxs_d & w_rxs_early) | (w_rxs & w_rxs_early);
`else
    logic w_unused_early;
    assign w_unused_early = w_rxs_early;
    assign w_sample       = w_rxs;
`endif

    assign w_tick = (r_cnt == CNT_LAST);

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_shift <= '0;
            r_rbyte <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_cnt   <= CNT_START;
                        r_bidx  <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        // High at the start-bit centre: a glitch, not a frame.
                        r_state <= w_sample ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        // Shift in at the MSB so the first bit ends at bit 0.
                        r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                        if (r_bidx == 3'(DATA_BITS - 1)) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bidx <= r_bidx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_sample) begin
                            r_rbyte <= r_shift;
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it yields a single ferr.
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rbyte = r_rbyte;
    assign ready = r_ready;
    assign ferr  = r_ferr;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rx_serial.sv
// Self-checking bench for rx_serial: table of directed frames plus
// hand-written sequences for glitch, break and mid-frame reset.
// Latency/backpressure: n/a (testbench).
module tb_rx_serial;

    localparam int R       = 108;
    localparam int H       = R / 2;
    localparam int STB_OFS = H + 9 * R + 3;  // drive cycle of start bit -> strobe cycle
`ifdef RX_SERIAL_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    logic       clk100 = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic [7:0] rbyte;
    logic       ready;
    logic       ferr;
    logic       busy;

    rx_serial #(.RCONST(R)) dut (
        .clk100 (clk100),
        .reset  (reset),
        .rx     (rx),
        .rbyte  (rbyte),
        .ready  (ready),
        .ferr   (ferr),
        .busy   (busy)
    );

    always #5 clk100 = ~clk100;

    int         cyc = 0;
    logic       rst_q = 1'b1;
    always @(posedge clk100) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    int         checks = 0;
    int         errors = 0;
    int         rdy_cnt = 0, ferr_cnt = 0, busy_cnt = 0;
    int         last_rdy_cyc = 0, last_ferr_cyc = 0, busy_rise_cyc = 0;
    logic [7:0] last_rdy_byte = 8'h00;
    logic [7:0] prev_rbyte = 8'h00;
    logic       prev_busy = 1'b0;

    // Continuous monitor on the falling edge.
    always @(negedge clk100) begin
        if (ready || ferr) begin
            checks++;
            if (ready && ferr) begin
                errors++;
                $display("FAIL strobe_exclusive: ready=%b ferr=%b, required not both", ready, ferr);
            end
        end
        if (ready) begin
            rdy_cnt++;
            last_rdy_cyc  = cyc;
            last_rdy_byte = rbyte;
        end
        if (ferr) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (rbyte !== prev_rbyte && !rst_q) begin
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL rbyte_hold: rbyte %h -> %h with ready=%b, required ready=1", prev_rbyte, rbyte, ready);
            end
        end
        prev_rbyte = rbyte;
        prev_busy  = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk100);
            #1 rx = 1'b1;
        end
    endtask

    // Drive one frame; glitch flips the line for one cycle at that frame
    // offset, cut stops driving after that many cycles (-1 = full frame).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch,
                              input int cut, output int start);
        logic v;
        start = 0;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = stop;
            else             v = d[b-1];
            for (int c = 0; c < R; c++) begin
                if (cut >= 0 && (b * R + c) >= cut) return;
                @(posedge clk100);
                #1;
                if (b == 0 && c == 0) start = cyc;
                rx = ((b * R + c) == glitch) ? ~v : v;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         glitch;
        int         idle_after;
        int         exp_rdy;
        int         exp_ferr;
        logic [7:0] exp_rbyte;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int st, r0, f0;

        vecs[0] = '{8'h41, 1'b1, -1,          0, 1, 0, 8'h41};
        vecs[1] = '{8'h00, 1'b1, -1,          0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, -1,          0, 1, 0, 8'hFF};
        vecs[3] = '{8'h0D, 1'b1, -1,          0, 1, 0, 8'h0D};
        vecs[4] = '{8'h00, 1'b1, 4 * R + H,  20, 1, 0, GLITCH_EXP};
        vecs[5] = '{8'hA5, 1'b0, -1,         50, 0, 1, GLITCH_EXP};
        vecs[6] = '{8'h80, 1'b1, -1,          0, 1, 0, 8'h80};
        vecs[7] = '{8'h7E, 1'b1, -1,          0, 1, 0, 8'h7E};

        // Reset state.
        repeat (3) @(posedge clk100);
        #1;
        check("reset_rbyte", 32'(rbyte), 32'h00);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_ferr",  32'(ferr),  32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        reset = 1'b0;
        idle(5);

        // Table of frames, mostly back-to-back.
        for (int i = 0; i < 8; i++) begin
            r0 = rdy_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch, -1, st);
            idle(vecs[i].idle_after);
            check($sformatf("v%0d_ready_cnt", i), 32'(rdy_cnt - r0), 32'(vecs[i].exp_rdy));
            check($sformatf("v%0d_ferr_cnt", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_rbyte", i), 32'(rbyte), 32'(vecs[i].exp_rbyte));
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'h0);
            if (vecs[i].exp_rdy == 1) begin
                check($sformatf("v%0d_ready_time", i), 32'(last_rdy_cyc - st), 32'(STB_OFS));
                check($sformatf("v%0d_ready_byte", i), 32'(last_rdy_byte), 32'(vecs[i].exp_rbyte));
            end
            if (vecs[i].exp_ferr == 1)
                check($sformatf("v%0d_ferr_time", i), 32'(last_ferr_cyc - st), 32'(STB_OFS));
        end

        // Bad stop bit followed by a long break.
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1, -1, st);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk100);
            #1 rx = 1'b0;
        end
        check("brk_ferr_cnt",  32'(ferr_cnt - f0), 32'd1);
        check("brk_ready_cnt", 32'(rdy_cnt - r0),  32'd0);
        check("brk_ferr_time", 32'(last_ferr_cyc - st), 32'(STB_OFS));
        check("brk_rbyte",     32'(rbyte), 32'h7E);
        check("brk_busy_held", 32'(busy),  32'h1);
        idle(5);
        check("brk_busy_release", 32'(busy), 32'h0);
        r0 = rdy_cnt;
        send_frame(8'h42, 1'b1, -1, -1, st);
        check("brk_next_ready", 32'(rdy_cnt - r0), 32'd1);
        check("brk_next_rbyte", 32'(rbyte), 32'h42);

        // 20-cycle low glitch on an idle line.
        idle(10);
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        busy_cnt = 0;
        @(posedge clk100);
        #1 rx = 1'b0;
        st = cyc;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk100);
            #1 rx = 1'b0;
        end
        idle(150);
        check("glitch_busy_rise", 32'(busy_rise_cyc - st), 32'd3);
        check("glitch_busy_len",  32'(busy_cnt), 32'(H));
        check("glitch_ready",     32'(rdy_cnt - r0), 32'd0);
        check("glitch_ferr",      32'(ferr_cnt - f0), 32'd0);

        // Reset pulse in the middle of data bit 4 of "C".
        send_frame(8'h43, 1'b1, -1, 5 * R + H, st);
        @(posedge clk100);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk100);
        #1;
        reset = 1'b0;
        check("midrst_rbyte", 32'(rbyte), 32'h00);
        check("midrst_ready", 32'(ready), 32'h0);
        check("midrst_ferr",  32'(ferr),  32'h0);
        check("midrst_busy",  32'(busy),  32'h0);
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        idle(10 * R);
        check("midrst_no_ready", 32'(rdy_cnt - r0), 32'd0);
        check("midrst_no_ferr",  32'(ferr_cnt - f0), 32'd0);
        send_frame(8'h44, 1'b1, -1, -1, st);
        idle(5);
        check("after_rst_ready", 32'(rdy_cnt - r0), 32'd1);
        check("after_rst_time",  32'(last_rdy_cyc - st), 32'(STB_OFS));
        check("after_rst_rbyte", 32'(rbyte), 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_serial.md
# rx_serial

UART receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first. It is the receive-side counterpart of `tx_serial` and uses the same bit-period parameter, so a `tx_serial`/`rx_serial` pair with equal `RCONST` interoperates. It sits between the `SERIAL_RX` pin of the `max10_02` top and the byte consumer, which can be the Enigma settings/text path. It delivers each received byte with a one-cycle strobe and flags framing errors.

## Interface
- `RCONST`, 108: clock cycles per bit (108 at 100 MHz is about 926 kbaud). Must be ≥ 8.
- `clk100`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle level is 1.
- `rbyte`  out  8  last correctly received byte; holds its value between frames.
- `ready`  out  1  one-cycle strobe; `rbyte` is valid and new in this cycle.
- `ferr`  out  1  one-cycle strobe; stop bit was sampled as 0.
- `busy`  out  1  high while a frame or a break is in progress.

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1) before any use. This section calls the synchronized signal `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK. A cycle counter `cnt` counts to `RCONST-1` and reloads. A bit index `bidx` counts 0..7.
- IDLE: when `rxs`==0 (call this cycle t0), go to START and load `cnt` so that the first sample falls at t0+`RCONST/2`. `RCONST/2` is floor division.
- START: at t0+`RCONST/2`, sample the line.
  - Sample is 1: treat as a false start and return to IDLE. No strobe.
  - Sample is 0: go to DATA.
- DATA: sample at t0+`RCONST/2`+k·`RCONST`, for k=1..8. Shift each sample into bit k−1 of the shift register (LSB first). After k=8, go to STOP.
- STOP: sample at t0+`RCONST/2`+9·`RCONST`.
  - Sample is 1: copy the shift register to `rbyte`, pulse `ready`, go to IDLE.
  - Sample is 0: pulse `ferr`, leave `rbyte` unchanged, go to BREAK.
- BREAK: stay until `rxs`==1, then go to IDLE. A continuous low line produces exactly one `ferr` and no further frames.
- `busy` = (state != IDLE). It is registered with the state, so it rises in the cycle after t0.
- A new start bit is accepted in the first cycle after return to IDLE. A frame that follows immediately (line falls at the stop-bit end) is therefore received.

## Timing
- All outputs reset to 0, and `rbyte` resets to 8'h00. The synchronizer resets to 1, the FSM resets to IDLE, and `cnt`/`bidx` reset to 0.
- Reset asserted mid-frame: the next cycle is IDLE, with no `ready` or `ferr` pulse. A frame in progress is discarded.
- Pin-to-`rxs` latency is 2 cycles.
- `ready`/`ferr` are asserted in the cycle after the stop sample, which is t0+`RCONST/2`+9·`RCONST`+1. Each is high for exactly one cycle.
- `ready` and `ferr` are never asserted in the same cycle.
- `rbyte` changes only in the cycle where `ready` is asserted.

## Configuration
- `RX_SERIAL_MAJORITY_EN` defined:
  - Each sample point (start, data, stop) uses a 2-of-3 majority vote.
  - The three values are `rxs` at centre−1, centre and centre+1 cycles.
  - Strobe timing is unchanged: the decision is made at centre+1, and `ready`/`ferr` still assert at stop centre+1.
- Not defined: one sample of `rxs` at the centre cycle.

## Structure
- Package `rx_serial_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - `DATA_BITS`=8 constant.
  - Counter width function, `$clog2(RCONST)`.
- One natural sub-module: `rx_sync`, the 2-FF synchronizer with synchronous reset to 1.
- The counter, FSM, shift register and optional vote logic stay in `rx_serial`.

## Test plan
- Loopback with `tx_serial`, `RCONST`=108, clk100=100 MHz:
  - Send "A" (8'h41): one `ready` pulse, `rbyte`=8'h41, `ferr` never high.
  - Send back-to-back 8'h00, 8'hFF, 8'h0D: three `ready` pulses in order, each `RCONST`·10 cycles apart, with matching `rbyte` values.
- Glitch tests:
  - Low pulse of 20 cycles on idle `rx`: `busy` rises, then returns low about 54 cycles later. No `ready` and no `ferr`.
  - Majority build only: 1-cycle high glitch on centre of data bit 3 of 8'h00. `rbyte`=8'h00.
  - Non-majority build, same glitch: `rbyte`=8'h08.
- Frame with stop bit driven 0, line then held low for 3000 cycles: one `ferr` pulse, `rbyte` keeps its previous value, `busy` stays high until `rx` returns to 1. The next valid "B" yields `rbyte`=8'h42.
- `reset` asserted for 1 cycle during data bit 4 of "C": no `ready`, all outputs 0. The following "D" is received correctly (`rbyte`=8'h44).
